// File: rtl/rv_mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package rv_mem_arb_pkg;

  typedef enum logic {
    DATA_PRI  = 1'b0,
    FETCH_PRI = 1'b1
  } pri_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  function automatic int unsigned calc_addr_w(input int unsigned mem_size_bytes);
    return $clog2(mem_size_bytes / 4);
  endfunction

endpackage

// File: rtl/rv_mem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module rv_mem_arb_sat_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Arbitrates one single-port word RAM between instruction fetch and data memory,
// with data priority bounded by a streak counter so fetch always makes progress.
module rv_mem_arbiter
  import rv_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTES  = 1024,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned ADDR_W          = calc_addr_w(MEM_SIZE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_Q100H,
  input  logic [31:0]       if_addr_Q100H,
  output logic              if_gnt_Q100H,
  output logic              if_rvalid_Q101H,
  output logic [31:0]       if_rdata_Q101H,

  input  logic              dm_req_Q103H,
  input  logic              dm_wr_en_Q103H,
  input  logic [31:0]       dm_addr_Q103H,
  input  logic [31:0]       dm_wr_data_Q103H,
  input  logic [3:0]        dm_byte_en_Q103H,
  output logic              dm_gnt_Q103H,
  output logic              dm_rvalid_Q104H,
  output logic [31:0]       dm_rdata_Q104H,

  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_byte_en,
  input  logic [31:0]       mem_rd_data,

  output logic [31:0]       fetch_stall_cnt
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(MAX_DATA_STREAK - 1);

  pri_state_e          state_q, state_d;
  owner_e              owner;
  logic [STREAK_W-1:0] streak_cnt;
  logic                streak_inc, streak_clr;
  logic                if_rd_pending, dm_rd_pending;
  logic                if_gnt, dm_gnt;

  // Grants are forced low while reset is asserted.
  always_comb begin
    owner = OWN_NONE;
    if (rst) begin
      if (state_q == FETCH_PRI) begin
        if (if_req_Q100H)      owner = OWN_IF;
        else if (dm_req_Q103H) owner = OWN_DM;
      end else begin
        if (dm_req_Q103H)      owner = OWN_DM;
        else if (if_req_Q100H) owner = OWN_IF;
      end
    end
  end

  assign if_gnt       = (owner == OWN_IF);
  assign dm_gnt       = (owner == OWN_DM);
  assign if_gnt_Q100H = if_gnt;
  assign dm_gnt_Q103H = dm_gnt;

  always_comb begin
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_byte_en = 4'b1111;
    unique case (owner)
      OWN_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr_Q100H[ADDR_W+1:2];
      end
      OWN_DM: begin
        mem_en    = 1'b1;
        mem_wr_en = dm_wr_en_Q103H;
        mem_addr  = dm_addr_Q103H[ADDR_W+1:2];
        if (dm_wr_en_Q103H) begin
          mem_wr_data = dm_wr_data_Q103H;
          mem_byte_en = dm_byte_en_Q103H;
        end
      end
      default: ;
    endcase
  end

  assign streak_inc = (state_q == DATA_PRI) && dm_gnt && if_req_Q100H;
  assign streak_clr = if_gnt || !if_req_Q100H;

  // With both requesters idle the state is held; a dropped fetch alone yields back to data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DATA_PRI: begin
        if (streak_inc && (streak_cnt == STREAK_LAST)) state_d = FETCH_PRI;
      end
      FETCH_PRI: begin
        if (if_gnt || (!if_req_Q100H && dm_req_Q103H)) state_d = DATA_PRI;
      end
      default: state_d = DATA_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= DATA_PRI;
      if_rd_pending <= 1'b0;
      dm_rd_pending <= 1'b0;
    end else begin
      state_q       <= state_d;
      if_rd_pending <= if_gnt;
      dm_rd_pending <= dm_gnt & ~dm_wr_en_Q103H;
    end
  end

  assign if_rvalid_Q101H = if_rd_pending;
  assign if_rdata_Q101H  = if_rd_pending ? mem_rd_data : 32'h0;
  assign dm_rvalid_Q104H = dm_rd_pending;
  assign dm_rdata_Q104H  = dm_rd_pending ? mem_rd_data : 32'h0;

  rv_mem_arb_sat_cnt #(
    .WIDTH (STREAK_W)
  ) u_streak_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (streak_inc),
    .clr   (streak_clr),
    .count (streak_cnt)
  );

  rv_mem_arb_sat_cnt #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_req_Q100H & ~if_gnt),
    .clr   (1'b0),
    .count (fetch_stall_cnt)
  );

  // Upper and byte-offset address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_Q100H[31:ADDR_W+2], if_addr_Q100H[1:0],
                              dm_addr_Q103H[31:ADDR_W+2], dm_addr_Q103H[1:0]};

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a write-first RAM model and a read-data scoreboard.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_Q100H = 1'b0;
  logic [31:0] if_addr_Q100H = '0;
  logic        if_gnt_Q100H;
  logic        if_rvalid_Q101H;
  logic [31:0] if_rdata_Q101H;
  logic        dm_req_Q103H = 1'b0;
  logic        dm_wr_en_Q103H = 1'b0;
  logic [31:0] dm_addr_Q103H = '0;
  logic [31:0] dm_wr_data_Q103H = '0;
  logic [3:0]  dm_byte_en_Q103H = '0;
  logic        dm_gnt_Q103H;
  logic        dm_rvalid_Q104H;
  logic [31:0] dm_rdata_Q104H;
  logic        mem_en;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] fetch_stall_cnt;

  int checks = 0;
  int passes = 0;
  int if_seen = 0;
  int dm_seen = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  always #5 clk = ~clk;

  rv_mem_arbiter #(
    .MEM_SIZE_BYTES  (1024),
    .MAX_DATA_STREAK (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req_Q100H     (if_req_Q100H),
    .if_addr_Q100H    (if_addr_Q100H),
    .if_gnt_Q100H     (if_gnt_Q100H),
    .if_rvalid_Q101H  (if_rvalid_Q101H),
    .if_rdata_Q101H   (if_rdata_Q101H),
    .dm_req_Q103H     (dm_req_Q103H),
    .dm_wr_en_Q103H   (dm_wr_en_Q103H),
    .dm_addr_Q103H    (dm_addr_Q103H),
    .dm_wr_data_Q103H (dm_wr_data_Q103H),
    .dm_byte_en_Q103H (dm_byte_en_Q103H),
    .dm_gnt_Q103H     (dm_gnt_Q103H),
    .dm_rvalid_Q104H  (dm_rvalid_Q104H),
    .dm_rdata_Q104H   (dm_rdata_Q104H),
    .mem_en           (mem_en),
    .mem_wr_en        (mem_wr_en),
    .mem_addr         (mem_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_byte_en      (mem_byte_en),
    .mem_rd_data      (mem_rd_data),
    .fetch_stall_cnt  (fetch_stall_cnt)
  );

  // Write-first synchronous RAM, word i preloaded with 0xA500_0000 + i.
  logic [31:0] ram [0:255];
  logic [31:0] ram_word;
  initial for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + i;

  always @(posedge clk) begin
    if (mem_en) begin
      ram_word = ram[mem_addr];
      if (mem_wr_en)
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) ram_word[8*b +: 8] = mem_wr_data[8*b +: 8];
      ram[mem_addr] = ram_word;
      mem_rd_data <= ram_word;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_Q100H   = 1'b0;
    dm_req_Q103H   = 1'b0;
    dm_wr_en_Q103H = 1'b0;
  endtask

  // Monitor: pops the expected word whenever a read response is presented.
  always @(negedge clk) begin
    if (if_rvalid_Q101H) begin
      if_seen++;
      if (if_q.size() == 0) check("if_unexpected_rvalid", 32'd1, 32'd0);
      else check("if_rdata", if_rdata_Q101H, if_q.pop_front());
    end else if (if_rdata_Q101H !== 32'h0) begin
      check("if_rdata_idle_zero", if_rdata_Q101H, 32'h0);
    end
    if (dm_rvalid_Q104H) begin
      dm_seen++;
      if (dm_q.size() == 0) check("dm_unexpected_rvalid", 32'd1, 32'd0);
      else check("dm_rdata", dm_rdata_Q104H, dm_q.pop_front());
    end else if (dm_rdata_Q104H !== 32'h0) begin
      check("dm_rdata_idle_zero", dm_rdata_Q104H, 32'h0);
    end
  end

  initial begin
    // Reset with both requests raised: nothing may be granted.
    #1;
    if_req_Q100H = 1'b1;
    dm_req_Q103H = 1'b1;
    @(negedge clk);
    check("rst_if_gnt", 32'(if_gnt_Q100H), 32'd0);
    check("rst_dm_gnt", 32'(dm_gnt_Q103H), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    step();
    rst = 1'b1;
    idle();
    @(negedge clk);
    check("rst_stall_cnt", fetch_stall_cnt, 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid_Q101H), 32'd0);
    step();

    // Fetch only, three consecutive words.
    if_req_Q100H = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_addr_Q100H = 32'(4 * i);
      @(negedge clk);
      check("fetch_gnt", 32'(if_gnt_Q100H), 32'd1);
      check("fetch_mem_addr", 32'(mem_addr), 32'(i));
      if_q.push_back(32'hA500_0000 + i);
      step();
    end
    idle();
    @(negedge clk);
    check("fetch_stall_zero", fetch_stall_cnt, 32'd0);
    step();

    // Full-word store then load of the same address.
    dm_req_Q103H = 1'b1; dm_wr_en_Q103H = 1'b1; dm_addr_Q103H = 32'h10;
    dm_wr_data_Q103H = 32'hDEAD_BEEF; dm_byte_en_Q103H = 4'b1111;
    @(negedge clk);
    check("store_gnt", 32'(dm_gnt_Q103H), 32'd1);
    check("store_mem_wr_en", 32'(mem_wr_en), 32'd1);
    step();
    dm_wr_en_Q103H = 1'b0; dm_byte_en_Q103H = 4'b0000;
    @(negedge clk);
    check("load_gnt", 32'(dm_gnt_Q103H), 32'd1);
    check("load_byte_en_forced", 32'(mem_byte_en), 32'hF);
    check("load_mem_wr_en", 32'(mem_wr_en), 32'd0);
    dm_q.push_back(32'hDEAD_BEEF);
    step();
    idle();
    step();

    // Fairness: both held for 12 cycles, expected D,D,D,D,F repeating.
    if_req_Q100H = 1'b1; if_addr_Q100H = 32'h20;
    dm_req_Q103H = 1'b1; dm_wr_en_Q103H = 1'b0; dm_addr_Q103H = 32'h24;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((i % 5) == 4) begin
        check("fair_if_gnt", 32'(if_gnt_Q100H), 32'd1);
        check("fair_dm_gnt", 32'(dm_gnt_Q103H), 32'd0);
        if_q.push_back(32'hA500_0008);
      end else begin
        check("fair_if_gnt", 32'(if_gnt_Q100H), 32'd0);
        check("fair_dm_gnt", 32'(dm_gnt_Q103H), 32'd1);
        dm_q.push_back(32'hA500_0009);
      end
      step();
    end
    idle();
    @(negedge clk);
    check("fair_stall_cnt", fetch_stall_cnt, 32'd10);
    step();

    // Out-of-range load wraps to word 4.
    dm_req_Q103H = 1'b1; dm_addr_Q103H = 32'h410;
    @(negedge clk);
    check("wrap_gnt", 32'(dm_gnt_Q103H), 32'd1);
    check("wrap_mem_addr", 32'(mem_addr), 32'd4);
    dm_q.push_back(32'hDEAD_BEEF);
    step();
    idle();
    step();

    // Reset in the cycle after a fetch grant drops the in-flight read.
    if_req_Q100H = 1'b1; if_addr_Q100H = 32'h0;
    @(negedge clk);
    check("pre_rst_if_gnt", 32'(if_gnt_Q100H), 32'd1);
    step();
    rst = 1'b0;
    dm_req_Q103H = 1'b1; dm_addr_Q103H = 32'h10;
    @(negedge clk);
    check("mid_rst_if_rvalid", 32'(if_rvalid_Q101H), 32'd0);
    check("mid_rst_if_gnt", 32'(if_gnt_Q100H), 32'd0);
    check("mid_rst_dm_gnt", 32'(dm_gnt_Q103H), 32'd0);
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_stall_cnt", fetch_stall_cnt, 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_dm_gnt", 32'(dm_gnt_Q103H), 32'd1);
    check("post_rst_if_gnt", 32'(if_gnt_Q100H), 32'd0);
    check("post_rst_if_rvalid", 32'(if_rvalid_Q101H), 32'd0);
    check("post_rst_stall_cnt", fetch_stall_cnt, 32'd0);
    dm_q.push_back(32'hDEAD_BEEF);
    step();
    idle();
    @(negedge clk);
    check("post_rst_stall_one", fetch_stall_cnt, 32'd1);
    step();

    // Byte store into the top lane, then read back the merged word.
    dm_req_Q103H = 1'b1; dm_wr_en_Q103H = 1'b1; dm_addr_Q103H = 32'h13;
    dm_wr_data_Q103H = 32'hAB00_0000; dm_byte_en_Q103H = 4'b1000;
    @(negedge clk);
    check("byte_store_gnt", 32'(dm_gnt_Q103H), 32'd1);
    check("byte_store_byte_en", 32'(mem_byte_en), 32'h8);
    step();
    dm_wr_en_Q103H = 1'b0; dm_addr_Q103H = 32'h10;
    @(negedge clk);
    check("byte_load_gnt", 32'(dm_gnt_Q103H), 32'd1);
    dm_q.push_back(32'hABAD_BEEF);
    step();
    idle();
    repeat (3) step();

    check("if_responses", 32'(if_seen), 32'd5);
    check("dm_responses", 32'(dm_seen), 32'd14);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("dm_queue_drained", 32'(dm_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port synchronous-read word RAM between the instruction-fetch requester (Q100H) and the data-memory requester (Q103H).
- Data accesses have priority by default. A streak counter guarantees forward progress for fetch.
- Returns read data one cycle after grant, tagged to the owner: fetch data at Q101H, data-memory data at Q104H.
- Exports a saturating fetch-stall counter for performance debug.

Parameters:
- MEM_SIZE_BYTES, 1024: RAM capacity in bytes; power of two, at least 8.
- MAX_DATA_STREAK, 4: number of consecutive data grants that may block a pending fetch before fetch is forced through; at least 1.
- ADDR_W, $clog2(MEM_SIZE_BYTES/4): word-address width. Derived; must not be overridden.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Asynchronous reset, active-low: asserted when 0.
- if_req_Q100H  in  1  Fetch request.
- if_addr_Q100H  in  32  Fetch byte address; word aligned.
- if_gnt_Q100H  out  1  Fetch granted this cycle. Low while if_req_Q100H is high means the fetch is stalled.
- if_rvalid_Q101H  out  1  Fetch read data valid.
- if_rdata_Q101H  out  32  Fetch read data.
- dm_req_Q103H  in  1  Data request.
- dm_wr_en_Q103H  in  1  1 = store, 0 = load.
- dm_addr_Q103H  in  32  Data byte address.
- dm_wr_data_Q103H  in  32  Store data, already lane-aligned.
- dm_byte_en_Q103H  in  4  Store byte lanes.
- dm_gnt_Q103H  out  1  Data request granted this cycle.
- dm_rvalid_Q104H  out  1  Load data valid.
- dm_rdata_Q104H  out  32  Raw load word. Sign/zero extension is done downstream.
- mem_en  out  1  RAM access enable.
- mem_wr_en  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wr_data  out  32  RAM write data.
- mem_byte_en  out  4  RAM write byte lanes. Forced to 4'b1111 on reads.
- mem_rd_data  in  32  RAM read data, valid one cycle after a read enable.
- fetch_stall_cnt  out  32  Number of cycles in which if_req was high and if_gnt was low; saturates at 32'hFFFF_FFFF.

Behaviour:
- Grant logic is combinational from the requests and the registered state. At most one grant per cycle. mem_* outputs are driven combinationally from the winner.
- Word address is addr[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo MEM_SIZE_BYTES. addr[1:0] is ignored.
- Priority FSM has two states:
  - DATA_PRI (reset state): the data requester wins whenever dm_req is high.
  - FETCH_PRI: the fetch requester wins whenever if_req is high.
- Streak counter: width $clog2(MAX_DATA_STREAK+1); reset value 0.
  - In DATA_PRI, each cycle with dm_gnt=1 and if_req=1 increments the counter.
  - Any cycle with if_gnt=1 clears it.
  - A cycle with if_req=0 clears it.
  - When the counter reaches MAX_DATA_STREAK on an increment, the next state is FETCH_PRI.
- FETCH_PRI → DATA_PRI after the first cycle with if_gnt=1.
  - If if_req drops while in FETCH_PRI, return to DATA_PRI and clear the counter.
- If both requesters are idle, mem_en=0 and the FSM holds its state.
- Read latency is exactly 1 cycle. Owner tag registers:
  - if_rd_pending <= if_gnt.
  - dm_rd_pending <= dm_gnt & ~dm_wr_en.
- Return path:
  - if_rvalid_Q101H = if_rd_pending; if_rdata_Q101H = mem_rd_data when valid, else 0.
  - dm_rvalid_Q104H = dm_rd_pending; dm_rdata_Q104H = mem_rd_data when valid, else 0.
- A store produces no rvalid. A load to the address written in the previous cycle returns the new data (RAM is write-first; no arbiter forwarding).
- Requesters must hold their request and address stable until granted. The arbiter has no request queue.
- fetch_stall_cnt increments in any cycle with if_req & ~if_gnt; it never wraps.
- Reset, at any time including mid-access:
  - FSM → DATA_PRI; streak counter = 0; pending tags = 0; fetch_stall_cnt = 0.
  - All grants, rvalids and mem_en are 0 while rst=0, and rdata is 0.
  - An in-flight read that straddles reset is dropped: no rvalid after release.
- Simultaneous dm_req and if_req in the first cycle after reset release: data is granted.

Decomposition:
- Package rv_mem_arb_pkg holds:
  - The priority-state enum (DATA_PRI, FETCH_PRI).
  - Owner enum (OWN_NONE, OWN_IF, OWN_DM).
  - A localparam function for ADDR_W.
- One sub-module, rv_mem_arb_sat_cnt: a parameterised-width saturating counter with inc and clear inputs. It is instantiated for both the streak counter and the stall counter.

Test Plan:
- Fetch only, if_req=1 with addresses 0x0, 0x4, 0x8 over 3 cycles → if_gnt=1 every cycle. if_rdata_Q101H equals preloaded words 0, 1 and 2 one cycle after each grant. fetch_stall_cnt=0.
- Store 0xDEADBEEF to 0x10 with byte_en 1111, then a load from 0x10 → dm_gnt=1 both cycles. dm_rvalid_Q104H=1 only after the load. dm_rdata_Q104H=0xDEADBEEF. if_rvalid stays 0.
- Fairness with MAX_DATA_STREAK=4, both requests held high for 12 cycles → grant pattern D,D,D,D,F repeating. fetch_stall_cnt=10 (8 stalled cycles in full periods plus 2 in the partial period).
- Out-of-range load at 0x410 with MEM_SIZE_BYTES=1024 → mem_addr=4, returns word 4 (0xDEADBEEF if written in the previous test).
- Reset pulse (rst=0) in the cycle after a fetch grant → no if_rvalid after release. FSM back in DATA_PRI (a simultaneous request grants data). Counters read 0.
- Byte store 0xAB to 0x13 with byte_en 1000 over 0xDEADBEEF, then a load → dm_rdata_Q104H=0xABADBEEF.
